uart_receiver: RTL

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_bit_timer.sv | 40 ++++
 rtl/uart_receiver.sv | 132 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and receiver FSM states.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int CNT_W     = 16;
    localparam int IDX_W     = 4;

    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter; strobe marks a full bit period, mid marks half a bit.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic strobe,
    output logic mid
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST =
        (HALF > 0) ? CNT_W'(HALF - 1) : '0;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign strobe = (cnt_q == LAST);
    assign mid    = (cnt_q == HALF_LAST);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, MSB first, with a one-byte valid/ready output register.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             fe_q, fe_d;
    logic             ov_q, ov_d;

    logic restart;
    logic strobe;
    logic mid;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (CLK),
        .rst    (RESET),
        .restart(restart),
        .strobe (strobe),
        .mid    (mid)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q && !ready;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
        restart = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx == START_BIT) begin
                    restart = 1'b1;
                    idx_d   = '0;
                    state_d = (HALF == 0) ? DATA : START;
                end
            end
            START: begin
                if (mid) begin
                    if (rx == IDLE_LEVEL) begin
                        state_d = IDLE;
                    end else begin
                        restart = 1'b1;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (strobe) begin
                    shift_d = {shift_q[6:0], rx};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (strobe) begin
                    idx_d   = '0;
                    state_d = IDLE;
                    if (rx == STOP_BIT) begin
                        // Load only when the held byte is gone or leaving now
                        if (!valid_q || ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ov_d = 1'b1;
                        end
                    end else begin
                        fe_d    = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx == IDLE_LEVEL) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    assign data          = data_q;
    assign valid         = valid_q;
    assign framing_error = fe_q;
    assign overrun       = ov_q;

endmodule
